// File: rtl/lab71soc_irq_pkg.sv
// rtl/lab71soc_irq_pkg.sv - register map shared by the interrupt controller files
package lab71soc_irq_pkg;
  localparam logic [2:0] ADDR_PENDING  = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [2:0] ADDR_VECTOR   = 3'd4;
  localparam logic [2:0] ADDR_FORCE    = 3'd5;
  localparam logic [2:0] ADDR_RAW      = 3'd6;

  localparam int VECTOR_VALID_BIT = 15;
endpackage

// File: rtl/lab71soc_irq_src_cell.sv
// rtl/lab71soc_irq_src_cell.sv - one interrupt source: input sampling, rise detect, pending bit
module lab71soc_irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic edge_sel,
  input  logic clr,
  input  logic force_set,
  output logic pending,
  output logic raw
);
  logic r_s1;
  logic r_prev;
  logic r_pending;
  logic w_rise;

  assign w_rise  = r_s1 & ~r_prev;
  assign pending = r_pending;
  assign raw     = r_s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_s1   <= irq_in;
      r_prev <= r_s1;
      // set terms are OR-ed after the clear so a coincident rise or force wins
      if (edge_sel) r_pending <= (r_pending & ~clr) | w_rise | force_set;
      else          r_pending <= r_s1;
    end
  end
endmodule

// File: rtl/lab71soc_irq_ctrl.sv
// rtl/lab71soc_irq_ctrl.sv - interrupt controller top: register file, read mux, priority encoder, irq_out flop
module lab71soc_irq_ctrl
  import lab71soc_irq_pkg::*;
#(
  parameter int          NUM_SRC  = 8,
  parameter logic [15:0] MASK_RST = 16'h0,
  parameter logic [15:0] EDGE_RST = 16'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out
);
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_edge_sel;
  logic [15:0]        r_readdata;
  logic               r_irq_out;

  logic               w_wr;
  logic [NUM_SRC-1:0] w_wdata;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_force;
  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_raw;
  logic [NUM_SRC-1:0] w_active;
  logic [3:0]         w_vec_idx;
  logic               w_any;
  logic [15:0]        w_vector;
  logic [15:0]        w_rdata;
  logic               w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wdata  = writedata[NUM_SRC-1:0];
  assign w_clr    = (w_wr && address == ADDR_PENDING) ? w_wdata : '0;
  assign w_force  = (w_wr && address == ADDR_FORCE)   ? w_wdata : '0;
  assign w_active = w_pending & r_mask;
  assign w_any    = |w_active;
  assign w_unused = &{1'b0, writedata};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    lab71soc_irq_src_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in[g]),
      .edge_sel  (r_edge_sel[g]),
      .clr       (w_clr[g]),
      .force_set (w_force[g]),
      .pending   (w_pending[g]),
      .raw       (w_raw[g])
    );
  end

  // scan downward so the lowest active index is the last one assigned
  always_comb begin
    w_vec_idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_vec_idx = 4'(i);
    end
  end

  always_comb begin
    w_vector                   = 16'h0;
    w_vector[VECTOR_VALID_BIT] = w_any;
    w_vector[3:0]              = w_vec_idx;
  end

  always_comb begin
    w_rdata = 16'h0;
    case (address)
      ADDR_PENDING:  w_rdata = 16'(w_pending);
      ADDR_MASK:     w_rdata = 16'(r_mask);
      ADDR_EDGE_SEL: w_rdata = 16'(r_edge_sel);
      ADDR_ACTIVE:   w_rdata = 16'(w_active);
      ADDR_VECTOR:   w_rdata = w_vector;
      ADDR_RAW:      w_rdata = 16'(w_raw);
      default:       w_rdata = 16'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask     <= MASK_RST[NUM_SRC-1:0];
      r_edge_sel <= EDGE_RST[NUM_SRC-1:0];
      r_readdata <= 16'h0;
      r_irq_out  <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_MASK)     r_mask     <= w_wdata;
      if (w_wr && address == ADDR_EDGE_SEL) r_edge_sel <= w_wdata;
      r_readdata <= w_rdata;
      r_irq_out  <= w_any;
    end
  end

  assign readdata = r_readdata;
  assign irq_out  = r_irq_out;
endmodule
